demux_14_tdm: RTL and testbench
===============================

DEMUX_14_TDM -- requirements
Module: demux_14_tdm

Interface
REQ-001 Parameter: W, 4, width of one slot word.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: din  input  W  slot word, sampled when din_valid=1.
REQ-005 Port: din_valid  input  1  din carries a slot word this cycle.
REQ-006 Port: sync  input  1  marks din as slot 0; ignored when din_valid=0.
REQ-007 Port: dout  output  4*W  frame register; bits [W*k+W-1:W*k] hold channel k.
REQ-008 Port: frame_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-009 Port: sync_err  output  1  one-cycle pulse on a misplaced or missing sync.
REQ-010 Port: slot  output  2  index of the next expected slot.

Function
REQ-011 The state machine SHALL have two states: HUNT and LOCK.
- HUNT: words without sync are discarded.
- HUNT, din_valid&sync: capture din into ch0, slot=1, go to LOCK.
REQ-012 In LOCK, each accepted word SHALL be written to the assembly register selected by slot, via a 2:4 one-hot decode; slot then increments.
REQ-013 Slot SHALL wrap 3->0 after capturing ch3.
REQ-014 On capture of slot 3, the next cycle SHALL copy ch0..ch2 plus the new ch3 into dout and pulse frame_valid; latency is 1 clock from the slot-3 edge.
REQ-015 In LOCK, din_valid&sync with slot!=0 SHALL behave as follows:
- pulse sync_err;
- discard the partial frame;
- capture din as ch0; slot=1; stay LOCK.
REQ-016 In LOCK, din_valid with slot==0 and sync=0 SHALL pulse sync_err, discard the word, and return to HUNT.
REQ-017 din_valid=0 SHALL hold all state; gaps between slots of any length are legal.
REQ-018 dout SHALL change only on frame_valid cycles; partial frames never appear on dout.
REQ-019 frame_valid and sync_err SHALL be registered and never high in the same cycle except as in REQ-015, where a completed prior frame is not involved.

Reset
REQ-020 While rst_n=0 at a clk edge, the block SHALL set:
- state=HUNT, slot=0;
- dout=0 and assembly registers=0;
- frame_valid=0, sync_err=0.
REQ-021 Reset asserted mid-frame SHALL drop the partial frame with no frame_valid or sync_err pulse.

Configuration
REQ-022 Macro TDM_PARITY_EN:
- When defined: the frame has a fifth slot (slot 4) carrying even parity, i.e. the bitwise XOR of ch0..ch3, and slot widens to 3 bits.
- When defined: a parity output par_err (1 bit, one-cycle pulse) is added.
- When defined: after slot 4, a match pulses frame_valid; a mismatch pulses par_err and leaves dout unchanged.
- When undefined: four slots only, slot is 2 bits, no par_err port.
REQ-023 With TDM_PARITY_EN defined, slot SHALL wrap 4->0 and REQ-016 applies at slot 0 as before.

Structure
REQ-024 A shared package SHALL hold the state enum (HUNT, LOCK) and the constant NUM_CH=4.
REQ-025 The one-hot slot decode SHALL be a sub-module slot_decoder_24: 2-bit in, 4-bit one-hot out, gated by an enable input.

Verification
REQ-026 Reset, then sync+A,B,C,D on consecutive cycles (W=4: 1,2,3,4) -> one cycle after the last word, frame_valid=1 and dout=16'h4321.
REQ-027 Words 5,6 without sync, then sync+1,2,3,4 -> first two dropped; dout=16'h4321, no sync_err.
REQ-028 sync+1,2, then sync+7,8,9,A -> sync_err pulse on the second sync; dout=16'hA987.
REQ-029 sync+1,2,3,4, then a word without sync at slot 0 -> sync_err pulse, state HUNT, dout keeps 16'h4321.
REQ-030 sync+1,2, rst_n=0 for one cycle, then sync+5,6,7,8 -> no pulse during reset; dout=16'h8765.
REQ-031 TDM_PARITY_EN, sync+1,2,3,4 with parity 4 -> frame_valid; the same frame with parity 5 -> par_err pulse and dout unchanged.

Source files
------------

// File: rtl/demux_14_tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// TDM_PARITY_EN adds a fifth (parity) slot to each frame.
package demux_14_tdm_pkg;

   typedef enum logic {StHunt, StLock} state_e;

   localparam int unsigned NUM_CH = 4;

`ifdef TDM_PARITY_EN
   localparam int unsigned NUM_SLOTS = NUM_CH + 1;
`else
   localparam int unsigned NUM_SLOTS = NUM_CH;
`endif

   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

endpackage

// File: rtl/slot_decoder_24.sv
// 2:4 one-hot decoder gated by an enable; selects the assembly register to write.
module slot_decoder_24 (
   input  logic       en_i,
   input  logic [1:0] sel_i,
   output logic [3:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[sel_i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_14_tdm.sv
// Demultiplexes a sync-marked slot stream into 4-channel frames.
// Macro TDM_PARITY_EN: adds an even-parity slot 4 and the par_err output.
module demux_14_tdm
   import demux_14_tdm_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [W-1:0]        din,
   input  logic                din_valid,
   input  logic                sync,
   output logic [NUM_CH*W-1:0] dout,
   output logic                frame_valid,
   output logic                sync_err,
`ifdef TDM_PARITY_EN
   output logic                par_err,
`endif
   output logic [SLOT_W-1:0]   slot
);

   state_e                       state_q, state_d;
   logic [SLOT_W-1:0]            slot_q, slot_d;
   logic [NUM_CH-1:0][W-1:0]     ch_q, ch_d;
   logic [NUM_CH*W-1:0]          dout_q, dout_d;
   logic                         fv_q, fv_d;
   logic                         se_q, se_d;
   logic                         wr_en;
   logic [1:0]                   wr_sel;
   logic                         clr_partial;
   logic [NUM_CH-1:0]            wr_onehot;
`ifdef TDM_PARITY_EN
   logic                         pe_q, pe_d;
   logic [W-1:0]                 par_calc;

   always_comb begin
      par_calc = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         par_calc = par_calc ^ ch_q[k];
      end
   end
`endif

   slot_decoder_24 u_slot_decoder (
      .en_i     (wr_en),
      .sel_i    (wr_sel),
      .onehot_o (wr_onehot)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      dout_d      = dout_q;
      fv_d        = 1'b0;
      se_d        = 1'b0;
      wr_en       = 1'b0;
      wr_sel      = slot_q[1:0];
      clr_partial = 1'b0;
`ifdef TDM_PARITY_EN
      pe_d        = 1'b0;
`endif
      if (din_valid) begin
         unique case (state_q)
            StHunt: begin
               if (sync) begin
                  clr_partial = 1'b1;
                  wr_en       = 1'b1;
                  wr_sel      = 2'd0;
                  slot_d      = SLOT_W'(1);
                  state_d     = StLock;
               end
            end
            StLock: begin
               if (sync && slot_q != '0) begin
                  // Early sync: drop the partial frame and restart at this word.
                  se_d        = 1'b1;
                  clr_partial = 1'b1;
                  wr_en       = 1'b1;
                  wr_sel      = 2'd0;
                  slot_d      = SLOT_W'(1);
               end else if (!sync && slot_q == '0) begin
                  se_d    = 1'b1;
                  state_d = StHunt;
`ifdef TDM_PARITY_EN
               end else if (slot_q == SLOT_W'(NUM_CH)) begin
                  if (din == par_calc) begin
                     dout_d = ch_q;
                     fv_d   = 1'b1;
                  end else begin
                     pe_d = 1'b1;
                  end
                  slot_d = '0;
               end else begin
                  wr_en  = 1'b1;
                  slot_d = slot_q + SLOT_W'(1);
               end
`else
               end else begin
                  wr_en = 1'b1;
                  if (slot_q == SLOT_W'(NUM_CH - 1)) begin
                     dout_d = {din, ch_q[NUM_CH-2:0]};
                     fv_d   = 1'b1;
                     slot_d = '0;
                  end else begin
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end
`endif
            end
         endcase
      end
   end

   always_comb begin
      ch_d = ch_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (clr_partial) begin
            ch_d[k] = '0;
         end
         if (wr_onehot[k]) begin
            ch_d[k] = din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StHunt;
         slot_q  <= '0;
         ch_q    <= '0;
         dout_q  <= '0;
         fv_q    <= 1'b0;
         se_q    <= 1'b0;
`ifdef TDM_PARITY_EN
         pe_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         ch_q    <= ch_d;
         dout_q  <= dout_d;
         fv_q    <= fv_d;
         se_q    <= se_d;
`ifdef TDM_PARITY_EN
         pe_q    <= pe_d;
`endif
      end
   end

   assign dout        = dout_q;
   assign frame_valid = fv_q;
   assign sync_err    = se_q;
   assign slot        = slot_q;
`ifdef TDM_PARITY_EN
   assign par_err     = pe_q;
`endif

endmodule

// File: tb/tb_demux_14_tdm.sv
// Bench for demux_14_tdm: directed scenarios plus a randomized stream checked
// against a queue-based frame model. Honors TDM_PARITY_EN.
module tb_demux_14_tdm;
   import demux_14_tdm_pkg::*;

   localparam int unsigned W = 4;
`ifdef TDM_PARITY_EN
   localparam int FRAME = 5;
`else
   localparam int FRAME = 4;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [W-1:0]      din = '0;
   logic              din_valid = 1'b0;
   logic              sync = 1'b0;
   logic [4*W-1:0]    dout;
   logic              frame_valid;
   logic              sync_err;
   logic [SLOT_W-1:0] slot;
`ifdef TDM_PARITY_EN
   logic              par_err;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of words accepted in the current frame.
   bit          m_lock;
   logic [3:0]  m_words[$];
   logic [15:0] m_dout;
   bit          m_fv, m_se, m_pe;

   demux_14_tdm #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .dout        (dout),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
`ifdef TDM_PARITY_EN
      .par_err     (par_err),
`endif
      .slot        (slot)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic [3:0] d, input bit v, input bit s, input bit rn);
      logic [3:0] x;
      m_fv = 1'b0;
      m_se = 1'b0;
      m_pe = 1'b0;
      if (!rn) begin
         m_lock = 1'b0;
         m_words.delete();
         m_dout = '0;
         return;
      end
      if (!v) return;
      if (!m_lock) begin
         if (s) begin
            m_words = {d};
            m_lock  = 1'b1;
         end
         return;
      end
      if (s && m_words.size() != 0) begin
         m_se    = 1'b1;
         m_words = {d};
         return;
      end
      if (!s && m_words.size() == 0) begin
         m_se   = 1'b1;
         m_lock = 1'b0;
         return;
      end
      m_words.push_back(d);
      if (m_words.size() == FRAME) begin
         x = m_words[0] ^ m_words[1] ^ m_words[2] ^ m_words[3];
         if (FRAME == 4 || d == x) begin
            m_dout = {m_words[3], m_words[2], m_words[1], m_words[0]};
            m_fv   = 1'b1;
         end else begin
            m_pe = 1'b1;
         end
         m_words.delete();
      end
   endtask

   task automatic drive(input logic [3:0] d, input bit v, input bit s);
      @(negedge clk);
      din       = d;
      din_valid = v;
      sync      = s;
      @(posedge clk);
      model_step(d, v, s, rst_n);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;
      @(posedge clk);
      model_step(4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_frame(input logic [15:0] f);
      drive(f[3:0], 1'b1, 1'b1);
      drive(f[7:4], 1'b1, 1'b0);
      drive(f[11:8], 1'b1, 1'b0);
      drive(f[15:12], 1'b1, 1'b0);
`ifdef TDM_PARITY_EN
      drive(f[3:0] ^ f[7:4] ^ f[11:8] ^ f[15:12], 1'b1, 1'b0);
`endif
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dout !== 16'h0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || slot !== '0) begin
         errors++;
         $display("FAIL reset: dout=%h fv=%b se=%b slot=%0d, required 0 0 0 0",
                  dout, frame_valid, sync_err, slot);
      end
   endtask

   task automatic test_basic_frame();
      apply_reset();
      send_frame(16'h4321);
      checks++;
      if (frame_valid !== 1'b1 || dout !== 16'h4321 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_frame: fv=%b dout=%h se=%b, required 1 4321 0",
                  frame_valid, dout, sync_err);
      end
      drive(4'h0, 1'b0, 1'b0);
      checks++;
      if (frame_valid !== 1'b0 || dout !== 16'h4321 || slot !== '0) begin
         errors++;
         $display("FAIL basic_pulse: fv=%b dout=%h slot=%0d, required 0 4321 0",
                  frame_valid, dout, slot);
      end
   endtask

   task automatic test_hunt_discard();
      apply_reset();
      drive(4'h5, 1'b1, 1'b0);
      drive(4'h6, 1'b1, 1'b0);
      checks++;
      if (slot !== '0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL hunt_discard: slot=%0d se=%b, required 0 0", slot, sync_err);
      end
      drive(4'h1, 1'b1, 1'b1);
      checks++;
      if (slot !== SLOT_W'(1) || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL hunt_lock: slot=%0d se=%b, required 1 0", slot, sync_err);
      end
      drive(4'h2, 1'b1, 1'b0);
      drive(4'h3, 1'b1, 1'b0);
      drive(4'h4, 1'b1, 1'b0);
`ifdef TDM_PARITY_EN
      drive(4'h4, 1'b1, 1'b0);
`endif
      checks++;
      if (frame_valid !== 1'b1 || dout !== 16'h4321 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL hunt_frame: fv=%b dout=%h se=%b, required 1 4321 0",
                  frame_valid, dout, sync_err);
      end
   endtask

   task automatic test_resync();
      apply_reset();
      drive(4'h1, 1'b1, 1'b1);
      drive(4'h2, 1'b1, 1'b0);
      drive(4'h7, 1'b1, 1'b1);
      checks++;
      if (sync_err !== 1'b1 || frame_valid !== 1'b0 || slot !== SLOT_W'(1)) begin
         errors++;
         $display("FAIL resync_err: se=%b fv=%b slot=%0d, required 1 0 1",
                  sync_err, frame_valid, slot);
      end
      drive(4'h8, 1'b1, 1'b0);
      drive(4'h9, 1'b1, 1'b0);
      drive(4'hA, 1'b1, 1'b0);
`ifdef TDM_PARITY_EN
      drive(4'h7 ^ 4'h8 ^ 4'h9 ^ 4'hA, 1'b1, 1'b0);
`endif
      checks++;
      if (frame_valid !== 1'b1 || dout !== 16'hA987 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL resync_frame: fv=%b dout=%h se=%b, required 1 a987 0",
                  frame_valid, dout, sync_err);
      end
   endtask

   task automatic test_missing_sync();
      apply_reset();
      send_frame(16'h4321);
      drive(4'h5, 1'b1, 1'b0);
      checks++;
      if (sync_err !== 1'b1 || dout !== 16'h4321 || slot !== '0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL missing_sync: se=%b dout=%h slot=%0d fv=%b, required 1 4321 0 0",
                  sync_err, dout, slot, frame_valid);
      end
      // Back in HUNT, a further unsynced word is silently discarded.
      drive(4'h6, 1'b1, 1'b0);
      checks++;
      if (sync_err !== 1'b0 || slot !== '0 || dout !== 16'h4321) begin
         errors++;
         $display("FAIL missing_hunt: se=%b slot=%0d dout=%h, required 0 0 4321",
                  sync_err, slot, dout);
      end
   endtask

   task automatic test_mid_frame_reset();
      apply_reset();
      send_frame(16'h4321);
      drive(4'h1, 1'b1, 1'b1);
      drive(4'h2, 1'b1, 1'b0);
      @(negedge clk);
      rst_n     = 1'b0;
      din       = 4'h3;
      din_valid = 1'b1;
      sync      = 1'b0;
      @(posedge clk);
      model_step(4'h3, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (frame_valid !== 1'b0 || sync_err !== 1'b0 || slot !== '0 || dout !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: fv=%b se=%b slot=%0d dout=%h, required 0 0 0 0",
                  frame_valid, sync_err, slot, dout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(16'h8765);
      checks++;
      if (frame_valid !== 1'b1 || dout !== 16'h8765 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_frame: fv=%b dout=%h se=%b, required 1 8765 0",
                  frame_valid, dout, sync_err);
      end
   endtask

   task automatic test_gaps();
      apply_reset();
      drive(4'hB, 1'b1, 1'b1);
      for (int g = 0; g < 3; g++) drive(4'hF, 1'b0, 1'b1);
      drive(4'hC, 1'b1, 1'b0);
      drive(4'hF, 1'b0, 1'b0);
      drive(4'hD, 1'b1, 1'b0);
      checks++;
      if (slot !== SLOT_W'(3) || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL gaps_hold: slot=%0d fv=%b se=%b, required 3 0 0",
                  slot, frame_valid, sync_err);
      end
      for (int g = 0; g < 5; g++) drive(4'h0, 1'b0, 1'b0);
      drive(4'hE, 1'b1, 1'b0);
`ifdef TDM_PARITY_EN
      drive(4'hF, 1'b0, 1'b0);
      drive(4'hB ^ 4'hC ^ 4'hD ^ 4'hE, 1'b1, 1'b0);
`endif
      checks++;
      if (frame_valid !== 1'b1 || dout !== 16'hEDCB) begin
         errors++;
         $display("FAIL gaps_frame: fv=%b dout=%h, required 1 edcb", frame_valid, dout);
      end
   endtask

`ifdef TDM_PARITY_EN
   task automatic test_parity();
      apply_reset();
      send_frame(16'h4321);
      checks++;
      if (frame_valid !== 1'b1 || par_err !== 1'b0 || dout !== 16'h4321) begin
         errors++;
         $display("FAIL parity_ok: fv=%b pe=%b dout=%h, required 1 0 4321",
                  frame_valid, par_err, dout);
      end
      drive(4'h5, 1'b1, 1'b1);
      drive(4'h6, 1'b1, 1'b0);
      drive(4'h7, 1'b1, 1'b0);
      drive(4'h8, 1'b1, 1'b0);
      drive(4'h5, 1'b1, 1'b0);
      checks++;
      if (par_err !== 1'b1 || frame_valid !== 1'b0 || dout !== 16'h4321 || slot !== '0) begin
         errors++;
         $display("FAIL parity_bad: pe=%b fv=%b dout=%h slot=%0d, required 1 0 4321 0",
                  par_err, frame_valid, dout, slot);
      end
   endtask
`endif

   task automatic test_random();
      logic [3:0] d;
      bit         v, s;
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         d = 4'($urandom_range(0, 15));
         v = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0) s = 1'($urandom_range(0, 1));
         else s = (m_words.size() == 0);
`ifdef TDM_PARITY_EN
         if (m_words.size() == 4 && $urandom_range(0, 3) != 0)
            d = m_words[0] ^ m_words[1] ^ m_words[2] ^ m_words[3];
`endif
         drive(d, v, s);
         checks++;
         if (frame_valid !== m_fv || sync_err !== m_se || dout !== m_dout ||
             slot !== SLOT_W'(m_words.size())) begin
            errors++;
            $display("FAIL random[%0d]: fv=%b se=%b dout=%h slot=%0d, required %b %b %h %0d",
                     n, frame_valid, sync_err, dout, slot, m_fv, m_se, m_dout,
                     m_words.size());
         end
`ifdef TDM_PARITY_EN
         checks++;
         if (par_err !== m_pe) begin
            errors++;
            $display("FAIL random_par[%0d]: pe=%b, required %b", n, par_err, m_pe);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_hunt_discard();
      test_resync();
      test_missing_sync();
      test_mid_frame_reset();
      test_gaps();
`ifdef TDM_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
